// File: rtl/sample_compressor.sv
// Envelope-following compressor/limiter: tracks a peak envelope, derives a gain of
// threshold/envelope with a bit-serial divider, scales the sample and clamps it to +/-threshold.
module sample_compressor #(
    parameter int WIDTH         = 12,
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 8,
    parameter int GAIN_FRAC     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] incoming_sample,
    input  logic        [WIDTH-2:0] threshold,
    input  logic                    enable,
    output logic signed [WIDTH-1:0] modified_sample,
    output logic                    done,
    output logic                    busy
);

    localparam int MAG_W  = WIDTH - 1;
    localparam int GAIN_W = GAIN_FRAC + 1;
    localparam int PROD_W = WIDTH + GAIN_FRAC + 1;
    localparam int CNT_W  = $clog2(GAIN_FRAC + 1);

    localparam logic signed [WIDTH-1:0] MIN_S    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic        [MAG_W-1:0] MAG_MAX  = {MAG_W{1'b1}};
    localparam logic        [MAG_W-1:0] MAG_ONE  = {{(MAG_W-1){1'b0}}, 1'b1};
    localparam logic        [GAIN_W-1:0] UNITY   = {1'b1, {GAIN_FRAC{1'b0}}};
    localparam logic        [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic        [CNT_W-1:0] CNT_LAST = CNT_W'(GAIN_FRAC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENV  = 2'd1,
        ST_DIV  = 2'd2,
        ST_MUL  = 2'd3
    } state_t;

    state_t                  state_r;
    logic signed [WIDTH-1:0] sample_r;
    logic        [MAG_W-1:0] thr_r;
    logic                    en_r;
    logic        [MAG_W-1:0] env_r;
    logic        [MAG_W-1:0] rem_r;
    logic    [GAIN_FRAC-1:0] quo_r;
    logic                    unity_r;
    logic        [CNT_W-1:0] cnt_r;
    logic                    fin_r;
    logic signed [WIDTH-1:0] out_r;
    logic                    done_r;
    logic                    busy_r;

    logic        [WIDTH-1:0] rem_sh_s;
    logic        [MAG_W-1:0] rem_sub_s;
    logic                    rem_ge_s;
    logic       [GAIN_W-1:0] gain_s;
    logic signed [PROD_W-1:0] samp_x_s;
    logic signed [PROD_W-1:0] gain_x_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] scaled_s;

    // Magnitude of a sample; the most negative code saturates to the largest positive magnitude.
    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [WIDTH-1:0] s);
        if (s == MIN_S) begin
            return MAG_MAX;
        end else if (s[WIDTH-1]) begin
            return ~s[MAG_W-1:0] + MAG_ONE;
        end else begin
            return s[MAG_W-1:0];
        end
    endfunction

    // One envelope update: fast attack toward larger peaks, slow release toward smaller ones.
    function automatic logic [MAG_W-1:0] env_next(input logic [MAG_W-1:0] env,
                                                  input logic [MAG_W-1:0] mag);
        logic [MAG_W-1:0] diff;
        if (mag > env) begin
            diff = mag - env;
            return env + (diff >> ATTACK_SHIFT);
        end else begin
            diff = env - mag;
            return env - (diff >> RELEASE_SHIFT);
        end
    endfunction

    // Saturate the scaled product to the symmetric range [-lim, +lim].
    function automatic logic signed [WIDTH-1:0] clamp_sym(input logic signed [PROD_W-1:0] p,
                                                         input logic [MAG_W-1:0] lim);
        logic signed [PROD_W-1:0] lim_x;
        lim_x = {{(PROD_W-MAG_W){1'b0}}, lim};
        if (p > lim_x) begin
            return {1'b0, lim};
        end else if (p < -lim_x) begin
            return -{1'b0, lim};
        end else begin
            return p[WIDTH-1:0];
        end
    endfunction

    // Restoring-divide step and gain scaling datapath.
    always_comb begin
        rem_sh_s  = {rem_r, 1'b0};
        rem_ge_s  = (rem_sh_s >= {1'b0, env_r});
        rem_sub_s = rem_sh_s[MAG_W-1:0] - env_r;
        if (unity_r) begin
            gain_s = UNITY;
        end else begin
            gain_s = {1'b0, quo_r};
        end
        samp_x_s = {{(PROD_W-WIDTH){sample_r[WIDTH-1]}}, sample_r};
        gain_x_s = {{(PROD_W-GAIN_W){1'b0}}, gain_s};
        prod_s   = samp_x_s * gain_x_s;
        scaled_s = prod_s >>> GAIN_FRAC;
    end

    // Control FSM with envelope, divider and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            sample_r <= '0;
            thr_r    <= '0;
            en_r     <= 1'b0;
            env_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            unity_r  <= 1'b0;
            cnt_r    <= '0;
            fin_r    <= 1'b0;
            out_r    <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sample_r <= incoming_sample;
                        thr_r    <= threshold;
                        en_r     <= enable;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ENV;
                    end
                end
                ST_ENV: begin
                    if (en_r) begin
                        env_r <= env_next(env_r, abs_sat(sample_r));
                    end
                    cnt_r   <= '0;
                    state_r <= ST_DIV;
                end
                ST_DIV: begin
                    // First DIV cycle seeds the remainder; env <= threshold means unity gain.
                    if (cnt_r == '0) begin
                        rem_r   <= thr_r;
                        quo_r   <= '0;
                        unity_r <= (env_r <= thr_r);
                    end else begin
                        rem_r <= rem_ge_s ? rem_sub_s : rem_sh_s[MAG_W-1:0];
                        quo_r <= {quo_r[GAIN_FRAC-2:0], rem_ge_s};
                    end
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_MUL;
                    end
                    cnt_r <= cnt_r + CNT_ONE;
                end
                ST_MUL: begin
                    // MUL spans the done cycle so a start coinciding with done is ignored.
                    if (!fin_r) begin
                        out_r  <= en_r ? clamp_sym(scaled_s, thr_r) : sample_r;
                        done_r <= 1'b1;
                        fin_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        fin_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    fin_r   <= 1'b0;
                end
            endcase
        end
    end

    assign modified_sample = out_r;
    assign done            = done_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_sample_compressor.sv
// Scoreboard bench for sample_compressor: a driver pushes hand-computed results,
// a monitor pops and compares them whenever done is seen.
module tb_sample_compressor;

    localparam int WIDTH     = 12;
    localparam int GAIN_FRAC = 8;
    localparam int LATENCY   = GAIN_FRAC + 3;
    localparam int BUSY_LEN  = GAIN_FRAC + 4;

    logic                    clock;
    logic                    reset;
    logic                    start;
    logic signed [WIDTH-1:0] incoming_sample;
    logic        [WIDTH-2:0] threshold;
    logic                    enable;
    logic signed [WIDTH-1:0] modified_sample;
    logic                    done;
    logic                    busy;

    typedef struct {
        int val;
        int acc;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    int   cyc;

    sample_compressor #(
        .WIDTH(WIDTH), .ATTACK_SHIFT(2), .RELEASE_SHIFT(8), .GAIN_FRAC(GAIN_FRAC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .incoming_sample(incoming_sample),
        .threshold(threshold),
        .enable(enable),
        .modified_sample(modified_sample),
        .done(done),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Issue one sample, push its expected result, then measure the busy window.
    task automatic run_op(input string name, input int smp, input int thr, input logic en,
                          input int expv, input bit pulses);
        int   hi;
        exp_t e;
        @(negedge clock);
        incoming_sample = smp[WIDTH-1:0];
        threshold       = thr[WIDTH-2:0];
        enable          = en;
        start           = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        e.val  = expv;
        e.acc  = cyc;
        e.name = name;
        sb_q.push_back(e);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) hi++;
            else break;
            if (pulses && (hi == 3 || hi == 5 || hi == BUSY_LEN)) start = 1'b1;
        end
        chk({name, "_busy_len"}, hi, BUSY_LEN);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_value"}, int'(modified_sample), e.val);
                    chk({e.name, "_latency"}, cyc - e.acc, LATENCY);
                    chk({e.name, "_busy_at_done"}, int'(busy), 1);
                end
            end
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        clock           = 1'b0;
        reset           = 1'b1;
        start           = 1'b0;
        incoming_sample = '0;
        threshold       = '0;
        enable          = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("reset_out", int'(modified_sample), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        fork
            monitor();
            begin
                run_op("unity", 1000, 2047, 1'b1, 1000, 1'b0);

                // Abort an operation mid-flight; outputs clear without a clock edge.
                @(negedge clock);
                incoming_sample = 12'sd500;
                threshold       = 11'd100;
                enable          = 1'b1;
                start           = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
                repeat (4) @(negedge clock);
                chk("abort_busy_before", int'(busy), 1);
                #2 reset = 1'b0;
                #1;
                chk("abort_out", int'(modified_sample), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_busy", int'(busy), 0);
                repeat (2) @(negedge clock);
                reset = 1'b1;

                run_op("clamp_pos", 1000, 256, 1'b1, 256, 1'b0);
                run_op("clamp_neg", -1000, 256, 1'b1, -256, 1'b0);
                run_op("gain_red", 300, 256, 1'b1, 174, 1'b0);
                run_op("bypass", -2048, 100, 1'b0, -2048, 1'b0);
                run_op("sat_abs", -2048, 2047, 1'b1, -2047, 1'b0);
                run_op("env_frozen", 500, 512, 1'b1, 304, 1'b0);
                run_op("thr_zero", 700, 0, 1'b1, 0, 1'b1);
                run_op("floor_neg", -300, 256, 1'b1, -92, 1'b0);

                repeat (30) @(negedge clock);
                chk("pending_results", sb_q.size(), 0);
            end
        join_any
        disable fork;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
